serial_slice_adder: RTL and testbench
=====================================

SERIAL_SLICE_ADDER -- requirements
Module: serial_slice_adder

Interface
REQ-001 Parameter N, default 8: operand width in bits; N >= 2.
REQ-002 Parameter S, default 2: slice width added per clock; 1 <= S <= N, N divisible by S; slice count K = N/S.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin an operation; sampled on rising clk edge.
REQ-006 a  input  N  operand A, two's-complement or unsigned.
REQ-007 b  input  N  operand B.
REQ-008 cin  input  1  carry-in, add mode only.
REQ-009 sub  input  1  mode select: 0 = A+B+cin, 1 = A-B.
REQ-010 busy  output  1  high while slices are being processed.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 sum  output  N  result.
REQ-013 cout  output  1  carry-out (add) / no-borrow flag (sub).
REQ-014 ovf  output  1  signed overflow flag.

Function
REQ-015 FSM states SHALL be IDLE, RUN and FIN.
REQ-016 Start acceptance: start=1 SHALL be accepted in IDLE or FIN; it SHALL be ignored in RUN.
REQ-017 On acceptance, the block SHALL capture a, b (inverted to ~b when sub=1), sub and initial carry (cin when sub=0, 1 when sub=1), then enter RUN; slice index = 0.
REQ-018 Inputs a, b, cin and sub SHALL be don't-care after the accepting edge.
REQ-019 In RUN, each edge SHALL add slice i (bits i*S+S-1 .. i*S) of the captured operands plus the running carry, write the S-bit result into sum slice i, update the carry, and increment i; LSB slice first.
REQ-020 On the edge processing slice K-1, the FSM SHALL go to FIN, set cout = final carry and ovf = (carry into bit N-1) XOR (carry out of bit N-1).
REQ-021 Latency: for start accepted at edge t, busy SHALL be high from t+1 through t+K inclusive (K cycles), and done SHALL be high for exactly the cycle after edge t+K.
REQ-022 In FIN, done=1 for one cycle; the FSM SHALL go to IDLE on the next edge unless start=1, in which case it SHALL re-enter RUN (back-to-back operation, done and new busy never overlap).
REQ-023 sum, cout, ovf SHALL be stable from the done cycle until the edge after the next accepted start; intermediate slice values of sum MAY be visible during RUN.
REQ-024 busy and done SHALL never be high in the same cycle.
REQ-025 For S = N (K = 1) the block SHALL complete in one RUN cycle with identical results.
REQ-026 Sub mode: cout=1 iff A >= B unsigned; ovf per REQ-020.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force state IDLE, slice index 0, busy=0, done=0, sum=0, cout=0, ovf=0.
REQ-028 Reset asserted during RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.
REQ-029 start sampled on the first edge after rst_n deasserts SHALL be accepted.

Verification (N=8, S=2 unless stated)
REQ-030 Add: a=0x5A, b=0x33, cin=0, sub=0 -> done 4 cycles after the accepting edge; sum=0x8D, cout=0, ovf=1; busy high exactly 4 cycles.
REQ-031 Add carry chain: a=0xFF, b=0x01, cin=1 -> sum=0x01, cout=1, ovf=0.
REQ-032 Sub: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, ovf=0; then a=0x80, b=0x01, sub=1 issued in done cycle -> accepted back-to-back, sum=0x7F, cout=1, ovf=1.
REQ-033 start pulsed mid-RUN with different operands -> ignored; original result and 4-cycle latency unchanged.
REQ-034 rst_n pulled low in second RUN cycle -> all outputs 0 asynchronously, no done; after release, a=0x01, b=0x01 -> sum=0x02.
REQ-035 Parameter sweep S=1, S=8 (and N=16, S=4): random operands against a reference sum; latency = N/S cycles in every case.

Source files
------------

// File: rtl/serial_slice_adder.sv
// Multi-cycle adder/subtractor that processes one S-bit slice per clock, LSB slice first.
// Subtraction is done as A + ~B + 1, so cout reads as "no borrow" in sub mode.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// RUN   | adding slice idx_q of the captured operands each edge
// FIN   | done pulse; a new start here re-enters RUN directly
module serial_slice_adder #(
  parameter int N = 8,
  parameter int S = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int K  = N / S;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           carry_q, carry_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  int             base;
  logic [S-1:0]   slice_a, slice_b;
  logic [S:0]     slice_sum;
  logic           msb_cin;
  logic           last_slice;

  assign base       = int'(idx_q) * S;
  assign slice_a    = a_q[base +: S];
  assign slice_b    = b_q[base +: S];
  assign slice_sum  = {1'b0, slice_a} + {1'b0, slice_b} + {{S{1'b0}}, carry_q};
  // Carry into the slice MSB recovered from its sum bit; on the last slice this is carry into bit N-1.
  assign msb_cin    = slice_sum[S-1] ^ slice_a[S-1] ^ slice_b[S-1];
  assign last_slice = (idx_q == IW'(K - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: S] = slice_sum[S-1:0];
        carry_d          = slice_sum[S];
        if (last_slice) begin
          cout_d  = slice_sum[S];
          ovf_d   = msb_cin ^ slice_sum[S];
          idx_d   = '0;
          state_d = FIN;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_slice_adder.sv
// Bench for serial_slice_adder: directed N=8/S=2 sequence plus S=1, S=8 and N=16/S=4 sweeps,
// with expected results queued at issue time and compared when done pulses.
module tb_serial_slice_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;

  logic       start, cin, sub;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic        sw_start, sw_cin, sw_sub;
  logic [7:0]  sw_a8, sw_b8;
  logic [15:0] sw_a16, sw_b16;
  logic        s1_busy, s1_done, s1_cout, s1_ovf;
  logic [7:0]  s1_sum;
  logic        s8_busy, s8_done, s8_cout, s8_ovf;
  logic [7:0]  s8_sum;
  logic        w_busy, w_done, w_cout, w_ovf;
  logic [15:0] w_sum;

  res_t q_main[$], q_s1[$], q_s8[$], q_w[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  serial_slice_adder #(.N(8), .S(2)) u_main (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf));

  serial_slice_adder #(.N(8), .S(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .a(sw_a8), .b(sw_b8), .cin(sw_cin), .sub(sw_sub),
    .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf));

  serial_slice_adder #(.N(8), .S(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .a(sw_a8), .b(sw_b8), .cin(sw_cin), .sub(sw_sub),
    .busy(s8_busy), .done(s8_done), .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf));

  serial_slice_adder #(.N(16), .S(4)) u_w (
    .clk(clk), .rst_n(rst_n), .start(sw_start), .a(sw_a16), .b(sw_b16), .cin(sw_cin), .sub(sw_sub),
    .busy(w_busy), .done(w_done), .sum(w_sum), .cout(w_cout), .ovf(w_ovf));

  // Whole-word reference: A + B + cin, or A + ~B + 1 for subtract.
  function automatic res_t model(int n, logic [15:0] av, logic [15:0] bv, logic c, logic m);
    logic [16:0] full;
    logic [15:0] mask, bb;
    res_t r;
    mask   = (n == 16) ? 16'hFFFF : ((16'h1 << n) - 16'h1);
    bb     = m ? (~bv & mask) : (bv & mask);
    full   = {1'b0, av & mask} + {1'b0, bb} + {16'h0, (m ? 1'b1 : c)};
    r.sum  = full[15:0] & mask;
    r.cout = full[n];
    r.ovf  = (av[n-1] == bb[n-1]) && (r.sum[n-1] != av[n-1]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic m,
                       input res_t e);
    a = av; b = bv; cin = c; sub = m; start = 1'b1;
    q_main.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Returns at the falling edge inside the done cycle; poke>0 fires a stray start in RUN.
  task automatic collect(input string tag, input int poke);
    int   n = 0;
    int   busy_cnt = 0;
    bit   got = 0;
    bit   overlap = 0;
    res_t e;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (poke != 0 && n == poke) begin
        start = 1'b1; a = 8'hC3; b = 8'h3C; cin = 1'b1; sub = 1'b0;
      end
      if (poke != 0 && n == poke + 1) start = 1'b0;
      if (busy && done) overlap = 1;
      if (busy) busy_cnt++;
      if (done) got = 1;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_done_excl"}, overlap, 0);
    check({tag, "_latency"}, n - 1, 4);
    check({tag, "_busy_cycles"}, busy_cnt, 4);
    check({tag, "_sb_depth"}, q_main.size(), 1);
    if (q_main.size() != 0) begin
      e = q_main.pop_front();
      check({tag, "_sum"}, sum, e.sum);
      check({tag, "_cout"}, cout, e.cout);
      check({tag, "_ovf"}, ovf, e.ovf);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n1, n8, nw;
    bit   any_done;
    res_t e;
    logic [7:0] ra, rb;
    logic rc, rm;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_start = 1'b0; sw_a8 = '0; sw_b8 = '0; sw_a16 = '0; sw_b16 = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // start on the very first edge after release
    issue(8'h5A, 8'h33, 1'b0, 1'b0, '{sum: 16'h8D, cout: 1'b0, ovf: 1'b1});
    collect("add_5a_33", 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_not_busy", busy, 0);
    check("sum_held_idle", sum, 8'h8D);

    issue(8'hFF, 8'h01, 1'b1, 1'b0, '{sum: 16'h01, cout: 1'b1, ovf: 1'b0});
    collect("add_carry_chain", 0);
    @(negedge clk);

    issue(8'h10, 8'h20, 1'b0, 1'b1, '{sum: 16'hF0, cout: 1'b0, ovf: 1'b0});
    collect("sub_10_20", 0);
    // issued inside the done cycle: back-to-back
    issue(8'h80, 8'h01, 1'b0, 1'b1, '{sum: 16'h7F, cout: 1'b1, ovf: 1'b1});
    collect("sub_b2b_80_01", 0);
    @(negedge clk);

    issue(8'h12, 8'h34, 1'b0, 1'b0, '{sum: 16'h46, cout: 1'b0, ovf: 1'b0});
    collect("start_mid_run", 2);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rm = 1'($urandom);
      issue(ra, rb, rc, rm, model(8, {8'h0, ra}, {8'h0, rb}, rc, rm));
      collect($sformatf("rand%0d", i), 0);
    end
    @(negedge clk);

    issue(8'h5A, 8'h33, 1'b0, 1'b0, '{sum: 16'h8D, cout: 1'b0, ovf: 1'b1});
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    q_main.delete();
    any_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) any_done = 1;
    end
    check("abort_no_done", any_done, 0);
    rst_n = 1'b1;
    issue(8'h01, 8'h01, 1'b0, 1'b0, '{sum: 16'h02, cout: 1'b0, ovf: 1'b0});
    collect("after_abort", 0);
    @(negedge clk);

    for (int it = 0; it < 6; it++) begin
      sw_a8 = 8'($urandom); sw_b8 = 8'($urandom);
      sw_a16 = 16'($urandom); sw_b16 = 16'($urandom);
      sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      sw_start = 1'b1;
      q_s1.push_back(model(8, {8'h0, sw_a8}, {8'h0, sw_b8}, sw_cin, sw_sub));
      q_s8.push_back(model(8, {8'h0, sw_a8}, {8'h0, sw_b8}, sw_cin, sw_sub));
      q_w.push_back(model(16, sw_a16, sw_b16, sw_cin, sw_sub));
      @(posedge clk);
      #1;
      sw_start = 1'b0;
      n1 = 0; n8 = 0; nw = 0;
      for (int n = 1; n <= 12; n++) begin
        @(negedge clk);
        if (s1_done && n1 == 0) begin
          n1 = n; e = q_s1.pop_front();
          check("s1_sum", s1_sum, e.sum); check("s1_cout", s1_cout, e.cout); check("s1_ovf", s1_ovf, e.ovf);
        end
        if (s8_done && n8 == 0) begin
          n8 = n; e = q_s8.pop_front();
          check("s8_sum", s8_sum, e.sum); check("s8_cout", s8_cout, e.cout); check("s8_ovf", s8_ovf, e.ovf);
        end
        if (w_done && nw == 0) begin
          nw = n; e = q_w.pop_front();
          check("n16s4_sum", w_sum, e.sum); check("n16s4_cout", w_cout, e.cout); check("n16s4_ovf", w_ovf, e.ovf);
        end
      end
      check("s1_latency", n1 - 1, 8);
      check("s8_latency", n8 - 1, 1);
      check("n16s4_latency", nw - 1, 4);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
